// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta sinc decimation filter.
//   SD_DATA_W      default width of integrators, combs and result word
//   SD_OSR_W       width of the decimation ratio / decimation counter
//   sd_order_e     filter order encodings as seen on reg_order
//   sd_stage_count maps an order code to its number of integrator/comb stages
package sd_pkg;

  localparam int SD_DATA_W = 32;
  localparam int SD_OSR_W  = 8;

  typedef enum logic [1:0] {
    SD_SINC1     = 2'd0,
    SD_SINC2     = 2'd1,
    SD_SINC3     = 2'd2,
    SD_SINC3_ALT = 2'd3
  } sd_order_e;

  // Code 3 is an alias of sinc3, so anything above sinc2 uses three stages.
  function automatic logic [1:0] sd_stage_count(input logic [1:0] order);
    case (sd_order_e'(order))
      SD_SINC1: return 2'd1;
      SD_SINC2: return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sd_comb_chain.sv
// Comb (differentiator) section of the sinc filter.
//   clk      system clock, rising edge
//   clear    synchronous clear of the delay registers
//   enable   filter enable; low also clears the delay registers
//   dec      decimation cycle: delays load, comb_out is meaningful
//   stages   number of active comb stages (1..3)
//   int_val  selected integrator value (already matched to stage count)
//   comb_out output of the last active comb stage, combinational
module sd_comb_chain
  import sd_pkg::*;
#(
  parameter int DATA_W = SD_DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic              dec,
  input  logic [1:0]        stages,
  input  logic [DATA_W-1:0] int_val,
  output logic [DATA_W-1:0] comb_out
);

  logic [DATA_W-1:0] d1, d2, d3;
  logic [DATA_W-1:0] y1, y2, y3;

  // Full subtract chain is always computed; the stage count only selects the
  // tap, so unused stages simply see their delay held.
  always_comb begin
    y1 = int_val - d1;
    y2 = y1 - d2;
    y3 = y2 - d3;
    case (stages)
      2'd1:    comb_out = y1;
      2'd2:    comb_out = y2;
      default: comb_out = y3;
    endcase
  end

  // Each active delay captures its stage input; inactive ones hold.
  always_ff @(posedge clk) begin
    if (clear || !enable) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (dec) begin
      d1 <= int_val;
      if (stages >= 2'd2) d2 <= y1;
      if (stages >= 2'd3) d3 <= y2;
    end
  end

endmodule

// File: rtl/sd_sinc_filter.sv
// Sinc (CIC) decimation filter for one sigma-delta channel, SYSCLK domain.
//   SYSCLK      system clock, rising edge
//   SYSRST      synchronous active-high reset
//   sd_dsd_in   modulator bit (1 -> +1, 0 -> 0)
//   sd_clk_in   modulator clock level; its rising edge is the sample strobe
//   reg_en      enable; low clears filter state but keeps data_out
//   reg_order   0=sinc1, 1=sinc2, 2/3=sinc3
//   reg_osr     decimation ratio minus one
//   data_out    unsigned filter result
//   data_valid  one-cycle pulse when data_out updates
module sd_sinc_filter
  import sd_pkg::*;
#(
  parameter int DATA_W = SD_DATA_W
) (
  input  logic                SYSCLK,
  input  logic                SYSRST,
  input  logic                sd_dsd_in,
  input  logic                sd_clk_in,
  input  logic                reg_en,
  input  logic [1:0]          reg_order,
  input  logic [SD_OSR_W-1:0] reg_osr,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid
);

  logic                clk_q;
  logic                strobe;
  logic [DATA_W-1:0]   int1, int2, int3;
  logic [DATA_W-1:0]   int_sel;
  logic [DATA_W-1:0]   comb_out;
  logic [SD_OSR_W-1:0] cnt;
  logic                dec_q;
  logic [1:0]          settle_cnt;
  logic [1:0]          order_q;
  logic [1:0]          stages;
  logic                order_chg;

  assign stages    = sd_stage_count(reg_order);
  assign strobe    = sd_clk_in & ~clk_q;
  assign order_chg = (reg_order != order_q);

  always_comb begin
    case (stages)
      2'd1:    int_sel = int1;
      2'd2:    int_sel = int2;
      default: int_sel = int3;
    endcase
  end

  // Integrators add modulo 2^DATA_W; the wrap cancels in the combs. Each
  // stage accumulates the previous stage's pre-update value. The >= test on
  // the counter lets a reduced reg_osr take effect on the very next strobe.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST || !reg_en) begin
      clk_q <= 1'b0;
      int1  <= '0;
      int2  <= '0;
      int3  <= '0;
      cnt   <= '0;
      dec_q <= 1'b0;
    end else begin
      clk_q <= sd_clk_in;
      dec_q <= 1'b0;
      if (strobe) begin
        int1 <= int1 + {{(DATA_W-1){1'b0}}, sd_dsd_in};
        int2 <= int2 + int1;
        int3 <= int3 + int2;
        if (cnt >= reg_osr) begin
          cnt   <= '0;
          dec_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // The first N decimation events after reset, enable or an order change
  // only prime the comb delays, so their results are suppressed.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      settle_cnt <= '0;
      order_q    <= '0;
    end else if (!reg_en) begin
      data_valid <= 1'b0;
      settle_cnt <= '0;
      order_q    <= '0;
    end else begin
      data_valid <= 1'b0;
      order_q    <= reg_order;
      if (order_chg) begin
        settle_cnt <= '0;
      end else if (dec_q) begin
        if (settle_cnt >= stages) begin
          data_out   <= comb_out;
          data_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
    end
  end

  sd_comb_chain #(.DATA_W(DATA_W)) u_comb (
    .clk      (SYSCLK),
    .clear    (SYSRST),
    .enable   (reg_en),
    .dec      (dec_q),
    .stages   (stages),
    .int_val  (int_sel),
    .comb_out (comb_out)
  );

endmodule

// File: tb/tb_sd_sinc_filter.sv
`timescale 1ns/1ps
module tb_sd_sinc_filter;

  localparam int DATA_W = 32;

  logic              SYSCLK = 1'b0;
  logic              SYSRST = 1'b1;
  logic              sd_dsd_in = 1'b0;
  logic              sd_clk_in = 1'b0;
  logic              reg_en = 1'b0;
  logic [1:0]        reg_order = 2'd0;
  logic [7:0]        reg_osr = 8'd0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;

  sd_sinc_filter #(.DATA_W(DATA_W)) dut (
    .SYSCLK     (SYSCLK),
    .SYSRST     (SYSRST),
    .sd_dsd_in  (sd_dsd_in),
    .sd_clk_in  (sd_clk_in),
    .reg_en     (reg_en),
    .reg_order  (reg_order),
    .reg_osr    (reg_osr),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // Values driven on the next tick.
  logic       rst_drv = 1'b1;
  logic       en_drv = 1'b1;
  logic [1:0] order_drv = 2'd0;
  logic [7:0] osr_drv = 8'd0;

  // Reference bookkeeping: strobes the filter should see, and what it emitted.
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          last_strobe_cyc = 0;
  logic        prev_clk = 1'b0;
  logic [31:0] obs_data;
  logic        obs_valid;
  int          val_strobe[$];
  int          val_cyc[$];
  int          val_lat[$];
  logic [31:0] val_data[$];

  typedef struct {
    string      name;
    logic [1:0] order;
    logic [7:0] osr;
    int         period;
    bit         alt;
    int         n_strobes;
    int         first;
    longint     exp_data;
    int         exp_count;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One SYSCLK cycle: sample outputs at the falling edge, then drive inputs.
  task automatic applyStimulus(input logic clk_v, input logic dsd_v);
    @(negedge SYSCLK);
    cyc++;
    obs_data  = data_out;
    obs_valid = data_valid;
    if (data_valid) begin
      val_strobe.push_back(strobe_cnt);
      val_cyc.push_back(cyc);
      val_lat.push_back(cyc - last_strobe_cyc);
      val_data.push_back(data_out);
    end
    SYSRST    = rst_drv;
    reg_en    = en_drv;
    reg_order = order_drv;
    reg_osr   = osr_drv;
    sd_clk_in = clk_v;
    sd_dsd_in = dsd_v;
    if (rst_drv || !en_drv) begin
      prev_clk   = 1'b0;
      strobe_cnt = 0;
    end else begin
      if (clk_v && !prev_clk) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      prev_clk = clk_v;
    end
  endtask

  task automatic clear_log();
    val_strobe.delete();
    val_cyc.delete();
    val_lat.delete();
    val_data.delete();
  endtask

  // n strobes, one every 'period' cycles; alt gives 1,0,1,0... else all ones.
  task automatic run_strobes(input int n, input int period, input bit alt);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = alt ? logic'(i % 2 == 0) : 1'b1;
      applyStimulus(1'b1, b);
      for (int j = 1; j < period; j++) applyStimulus(1'b0, b);
    end
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    en_drv  = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst_drv = 1'b0;
    applyStimulus(1'b0, 1'b0);
    clear_log();
  endtask

  initial begin
    // name, order, osr, period, alt, strobes, first valid strobe, data, count
    vecs[0] = '{"sinc1_d64",       2'd0, 8'd63,  4, 1'b0, 320,  128,  64,       4};
    // 4096 strobes push I3 past 2^32, so this also covers integrator wrap.
    vecs[1] = '{"sinc3_d256_wrap", 2'd2, 8'd255, 2, 1'b0, 4096, 1024, 16777216, 13};
    vecs[2] = '{"sinc2_d16_alt",   2'd1, 8'd15,  3, 1'b1, 160,  48,   128,      8};
    vecs[3] = '{"sinc3_code3_d4",  2'd3, 8'd3,   2, 1'b0, 40,   16,   64,       7};
    vecs[4] = '{"sinc1_d1",        2'd0, 8'd0,   3, 1'b0, 10,   2,    1,        9};
    vecs[5] = '{"sinc2_d256",      2'd1, 8'd255, 2, 1'b0, 1024, 768,  65536,    2};

    for (int v = 0; v < 6; v++) begin
      int d;
      d = int'(vecs[v].osr) + 1;
      order_drv = vecs[v].order;
      osr_drv   = vecs[v].osr;
      do_reset();
      checkOutput($sformatf("%s reset data_out", vecs[v].name), 64'(obs_data), 64'd0);
      checkOutput($sformatf("%s reset data_valid", vecs[v].name), 64'(obs_valid), 64'd0);
      run_strobes(vecs[v].n_strobes, vecs[v].period, vecs[v].alt);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("%s valid count", vecs[v].name), 64'(val_data.size()), 64'(vecs[v].exp_count));
      for (int k = 0; k < val_data.size(); k++) begin
        checkOutput($sformatf("%s data[%0d]", vecs[v].name, k), 64'(val_data[k]), 64'(vecs[v].exp_data));
        checkOutput($sformatf("%s strobe[%0d]", vecs[v].name, k), 64'(val_strobe[k]), 64'(vecs[v].first + k * d));
        checkOutput($sformatf("%s latency[%0d]", vecs[v].name, k), 64'(val_lat[k]), 64'd2);
        if (k > 0)
          checkOutput($sformatf("%s spacing[%0d]", vecs[v].name, k),
                      64'(val_cyc[k] - val_cyc[k-1]), 64'(d * vecs[v].period));
      end
    end

    // Synchronous reset in the middle of a frame after output is nonzero.
    order_drv = 2'd0;
    osr_drv   = 8'd63;
    do_reset();
    run_strobes(164, 4, 1'b0);
    checkOutput("midrst pre data_out", 64'(obs_data), 64'd64);
    rst_drv = 1'b1;
    applyStimulus(1'b0, 1'b1);
    rst_drv = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst data_out", 64'(obs_data), 64'd0);
    checkOutput("midrst data_valid", 64'(obs_valid), 64'd0);
    clear_log();
    run_strobes(127, 4, 1'b0);
    checkOutput("midrst no early valid", 64'(val_data.size()), 64'd0);
    run_strobes(1, 4, 1'b0);
    checkOutput("midrst valid count", 64'(val_data.size()), 64'd1);
    if (val_data.size() > 0) begin
      checkOutput("midrst data", 64'(val_data[0]), 64'd64);
      checkOutput("midrst strobe", 64'(val_strobe[0]), 64'd128);
    end

    // One-cycle enable drop mid-frame: data_out must hold.
    run_strobes(36, 4, 1'b0);
    en_drv = 1'b0;
    applyStimulus(1'b0, 1'b1);
    en_drv = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("endrop data_out hold", 64'(obs_data), 64'd64);
    checkOutput("endrop data_valid", 64'(obs_valid), 64'd0);
    clear_log();
    run_strobes(127, 4, 1'b0);
    checkOutput("endrop no early valid", 64'(val_data.size()), 64'd0);
    run_strobes(1, 4, 1'b0);
    checkOutput("endrop valid count", 64'(val_data.size()), 64'd1);
    if (val_data.size() > 0) begin
      checkOutput("endrop data", 64'(val_data[0]), 64'd64);
      checkOutput("endrop strobe", 64'(val_strobe[0]), 64'd128);
    end

    // reg_osr drops from 63 to 7 with cnt=20: decimate on strobe 21
    // (suppressed, primes the comb), then every 8 strobes.
    order_drv = 2'd0;
    osr_drv   = 8'd63;
    do_reset();
    run_strobes(20, 4, 1'b0);
    osr_drv = 8'd7;
    run_strobes(9, 4, 1'b0);
    checkOutput("osrchg valid count 1", 64'(val_data.size()), 64'd1);
    run_strobes(8, 4, 1'b0);
    checkOutput("osrchg valid count 2", 64'(val_data.size()), 64'd2);
    for (int k = 0; k < val_data.size(); k++) begin
      checkOutput($sformatf("osrchg data[%0d]", k), 64'(val_data[k]), 64'd8);
      checkOutput($sformatf("osrchg strobe[%0d]", k), 64'(val_strobe[k]), 64'(29 + 8 * k));
    end

    // sinc2 -> sinc3 while running: three suppressed events, then D^3.
    order_drv = 2'd1;
    osr_drv   = 8'd15;
    do_reset();
    run_strobes(60, 3, 1'b0);
    checkOutput("ordchg sinc2 data", 64'(obs_data), 64'd256);
    clear_log();
    order_drv = 2'd3;
    run_strobes(52, 3, 1'b0);
    checkOutput("ordchg valid count", 64'(val_data.size()), 64'd1);
    if (val_data.size() > 0) begin
      checkOutput("ordchg data", 64'(val_data[0]), 64'd4096);
      checkOutput("ordchg strobe", 64'(val_strobe[0]), 64'd112);
    end

    // sd_clk_in stuck high: only its initial rising edge counts.
    order_drv = 2'd0;
    osr_drv   = 8'd0;
    do_reset();
    run_strobes(5, 3, 1'b0);
    clear_log();
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("stuck valid count", 64'(val_data.size()), 64'd1);
    if (val_data.size() > 0)
      checkOutput("stuck latency", 64'(val_lat[0]), 64'd2);
    applyStimulus(1'b0, 1'b1);
    run_strobes(2, 3, 1'b0);
    checkOutput("stuck resume count", 64'(val_data.size()), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
